// File: rtl/regfile_scoreboard.sv
// Register file with per-entry pending-write scoreboard; a post-reset sweep zeroes every entry.
// Optional same-cycle write-to-read bypass is enabled by defining RF_BYPASS_EN.
module regfile_scoreboard #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] A1,
   input  logic [ADDR_W-1:0] A2,
   output logic [DATA_W-1:0] RD1,
   output logic [DATA_W-1:0] RD2,
   input  logic [ADDR_W-1:0] A3,
   input  logic [DATA_W-1:0] WD3,
   input  logic              WE3,
   input  logic              ISS,
   input  logic [ADDR_W-1:0] ISS_A,
   output logic              BUSY1,
   output logic              BUSY2,
   output logic              READY
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   typedef enum logic [0:0] {StClear, StRun} state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic              ready_q;
   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DEPTH-1:0]  pend_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StClear;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            StClear: begin
               cnt_q <= cnt_q + 1'b1;
               if (&cnt_q) begin
                  state_q <= StRun;
                  ready_q <= 1'b1;
               end
            end
            StRun: begin
               state_q <= StRun;
            end
            default: begin
               state_q <= StClear;
               cnt_q   <= '0;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   // Storage has no reset; the sweep is the only way entries return to zero.
   always_ff @(posedge clk) begin
      if (state_q == StClear) begin
         regs_q[cnt_q] <= '0;
         pend_q[cnt_q] <= 1'b0;
      end else begin
         if (WE3 && (A3 != '0)) begin
            regs_q[A3] <= WD3;
            pend_q[A3] <= 1'b0;
         end
         // Issue after write so a same-edge issue leaves the entry pending.
         if (ISS && (ISS_A != '0)) begin
            pend_q[ISS_A] <= 1'b1;
         end
      end
   end

   always_comb begin
      RD1   = '0;
      RD2   = '0;
      BUSY1 = 1'b0;
      BUSY2 = 1'b0;
      if (state_q == StRun) begin
         if (A1 != '0) begin
            RD1   = regs_q[A1];
            BUSY1 = pend_q[A1];
         end
         if (A2 != '0) begin
            RD2   = regs_q[A2];
            BUSY2 = pend_q[A2];
         end
`ifdef RF_BYPASS_EN
         if (WE3 && (A3 != '0) && (A3 == A1)) begin
            RD1   = WD3;
            BUSY1 = 1'b0;
         end
         if (WE3 && (A3 != '0) && (A3 == A2)) begin
            RD2   = WD3;
            BUSY2 = 1'b0;
         end
`endif
      end
   end

   assign READY = ready_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios plus randomized traffic against an array model.
module tb_regfile_scoreboard;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [4:0]  a1 = '0, a2 = '0, a3 = '0, iss_a = '0;
   logic [31:0] wd3 = '0;
   logic        we3 = 1'b0, iss = 1'b0;
   logic [31:0] rd1, rd2;
   logic        busy1, busy2, ready;

   logic        rst2 = 1'b0;
   logic [2:0]  b_a1 = '0, b_a2 = '0, b_a3 = '0, b_iss_a = '0;
   logic [63:0] b_wd3 = '0;
   logic        b_we3 = 1'b0, b_iss = 1'b0;
   logic [63:0] b_rd1, b_rd2;
   logic        b_busy1, b_busy2, b_ready;

   int vectors = 0;
   int errors  = 0;

   logic [31:0] m_regs [32];
   logic        m_pend [32];

   always #5 clk = ~clk;

   regfile_scoreboard dut (
      .clk(clk), .rst(rst), .A1(a1), .A2(a2), .RD1(rd1), .RD2(rd2),
      .A3(a3), .WD3(wd3), .WE3(we3), .ISS(iss), .ISS_A(iss_a),
      .BUSY1(busy1), .BUSY2(busy2), .READY(ready)
   );

   regfile_scoreboard #(.DATA_W(64), .ADDR_W(3)) dut_small (
      .clk(clk), .rst(rst2), .A1(b_a1), .A2(b_a2), .RD1(b_rd1), .RD2(b_rd2),
      .A3(b_a3), .WD3(b_wd3), .WE3(b_we3), .ISS(b_iss), .ISS_A(b_iss_a),
      .BUSY1(b_busy1), .BUSY2(b_busy2), .READY(b_ready)
   );

   // Expected read data for a RUN-state port, from the register rules.
   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
`ifdef RF_BYPASS_EN
      if (we3 && (a3 == a)) return wd3;
`endif
      return m_regs[a];
   endfunction

   function automatic logic exp_busy(input logic [4:0] a);
      if (a == 5'd0) return 1'b0;
`ifdef RF_BYPASS_EN
      if (we3 && (a3 == a)) return 1'b0;
`endif
      return m_pend[a];
   endfunction

   // Advance one RUN edge and apply its effect to the model.
   task automatic step();
      @(posedge clk);
      if (we3 && (a3 != 5'd0)) begin
         m_regs[a3] = wd3;
         m_pend[a3] = 1'b0;
      end
      if (iss && (iss_a != 5'd0)) m_pend[iss_a] = 1'b1;
      #1;
   endtask

   // Caller releases rst just after a rising edge; counts CLEAR cycles with busy inputs.
   task automatic sweep(input string tag);
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         if (ready) break;
         n++;
         vectors++;
         if (rd1 !== 32'd0 || rd2 !== 32'd0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL %s clear_outputs: rd1=%h rd2=%h b1=%b b2=%b, required all zero",
                     tag, rd1, rd2, busy1, busy2);
         end
         if (n >= 100) break;
         a1 = 5'($urandom); a2 = 5'($urandom);
         a3 = a1; iss_a = a2; wd3 = $urandom; we3 = 1'b1; iss = 1'b1;
      end
      we3 = 1'b0;
      iss = 1'b0;
      vectors++;
      if (n != 32) begin
         errors++;
         $display("FAIL %s clear_length: got %0d cycles, required 32", tag, n);
      end
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = 32'd0;
         m_pend[i] = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      a1 = 5'd5; a2 = 5'd9;
      #1;
      vectors++;
      if (ready !== 1'b0 || rd1 !== 32'd0 || busy1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: ready=%b rd1=%h busy1=%b, required 0/0/0", ready, rd1, busy1);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      sweep("initial");
      for (int i = 0; i < 32; i++) begin
         a1 = 5'(i);
         a2 = 5'(31 - i);
         @(negedge clk);
         vectors++;
         if (rd1 !== 32'd0 || rd2 !== 32'd0 || busy1 !== 1'b0 || busy2 !== 1'b0 || ready !== 1'b1)
         begin
            errors++;
            $display("FAIL post_clear_read r%0d: rd1=%h rd2=%h b1=%b b2=%b rdy=%b, required 0s, rdy=1",
                     i, rd1, rd2, busy1, busy2, ready);
         end
         step();
      end
   endtask

   task automatic test_write_read();
      we3 = 1'b1; a3 = 5'd5; wd3 = 32'hDEADBEEF;
      step();
      a3 = 5'd0; wd3 = 32'h1234; a1 = 5'd5;
      @(negedge clk);
      vectors++;
      if (rd1 !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL write_r5: rd1=%h, required deadbeef", rd1);
      end
      step();
      we3 = 1'b0; a2 = 5'd0;
      @(negedge clk);
      vectors++;
      if (rd2 !== 32'd0 || busy2 !== 1'b0) begin
         errors++;
         $display("FAIL write_r0: rd2=%h busy2=%b, required 0/0", rd2, busy2);
      end
      step();
   endtask

   task automatic test_scoreboard();
      iss = 1'b1; iss_a = 5'd7;
      step();
      iss = 1'b0; a1 = 5'd7;
      @(negedge clk);
      vectors++;
      if (busy1 !== 1'b1) begin
         errors++;
         $display("FAIL issue_r7: busy1=%b, required 1", busy1);
      end
      we3 = 1'b1; a3 = 5'd7; wd3 = 32'h55;
      step();
      we3 = 1'b0;
      @(negedge clk);
      vectors++;
      if (busy1 !== 1'b0 || rd1 !== 32'h55) begin
         errors++;
         $display("FAIL writeback_r7: busy1=%b rd1=%h, required 0/00000055", busy1, rd1);
      end
      we3 = 1'b1; a3 = 5'd9; wd3 = 32'h9999; iss = 1'b1; iss_a = 5'd9;
      step();
      we3 = 1'b0; iss = 1'b0; a1 = 5'd9; a2 = 5'd9;
      @(negedge clk);
      vectors++;
      if (rd1 !== 32'h9999 || busy1 !== 1'b1 || rd2 !== 32'h9999 || busy2 !== 1'b1) begin
         errors++;
         $display("FAIL same_edge_r9: rd1=%h b1=%b rd2=%h b2=%b, required 9999/1 on both",
                  rd1, busy1, rd2, busy2);
      end
      step();
   endtask

   task automatic test_bypass();
      logic [31:0] want_rd;
      logic        want_busy;
      we3 = 1'b1; a3 = 5'd3; wd3 = 32'h11111111; iss = 1'b1; iss_a = 5'd3;
      step();
      iss = 1'b0; wd3 = 32'hA5A5A5A5; a1 = 5'd3;
`ifdef RF_BYPASS_EN
      want_rd = 32'hA5A5A5A5; want_busy = 1'b0;
`else
      want_rd = 32'h11111111; want_busy = 1'b1;
`endif
      @(negedge clk);
      vectors++;
      if (rd1 !== want_rd || busy1 !== want_busy) begin
         errors++;
         $display("FAIL bypass_same_cycle: rd1=%h b1=%b, required %h/%b", rd1, busy1,
                  want_rd, want_busy);
      end
      step();
      we3 = 1'b0;
      @(negedge clk);
      vectors++;
      if (rd1 !== 32'hA5A5A5A5 || busy1 !== 1'b0) begin
         errors++;
         $display("FAIL bypass_next_cycle: rd1=%h b1=%b, required a5a5a5a5/0", rd1, busy1);
      end
      step();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         a1 = 5'($urandom);
         a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom);
         a3 = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 7));
         iss_a = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 7));
         wd3 = $urandom;
         we3 = 1'($urandom);
         iss = ($urandom_range(0, 2) == 0);
         @(negedge clk);
         vectors++;
         if (rd1 !== exp_rd(a1) || busy1 !== exp_busy(a1) || rd2 !== exp_rd(a2) ||
             busy2 !== exp_busy(a2) || ready !== 1'b1) begin
            errors++;
            $display("FAIL random c%0d a1=%0d a2=%0d: rd1=%h b1=%b rd2=%h b2=%b rdy=%b, required %h/%b %h/%b rdy=1",
                     c, a1, a2, rd1, busy1, rd2, busy2, ready,
                     exp_rd(a1), exp_busy(a1), exp_rd(a2), exp_busy(a2));
         end
         step();
      end
      we3 = 1'b0;
      iss = 1'b0;
   endtask

   task automatic test_reset_mid_clear();
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (10) @(negedge clk);
      rst = 1'b0;
      #1;
      vectors++;
      if (ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_clear: ready=%b, required 0", ready);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      sweep("mid_clear");
   endtask

   task automatic test_reset_mid_run();
      logic [31:0] val;
      val = $urandom | 32'h1;
      we3 = 1'b1; a3 = 5'd5; wd3 = val;
      step();
      we3 = 1'b0; a1 = 5'd5;
      @(negedge clk);
      vectors++;
      if (rd1 !== val) begin
         errors++;
         $display("FAIL pre_reset_r5: rd1=%h, required %h", rd1, val);
      end
      rst = 1'b0;
      #1;
      vectors++;
      if (ready !== 1'b0 || rd1 !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid_run: ready=%b rd1=%h, required 0/0", ready, rd1);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      sweep("mid_run");
      a1 = 5'd5;
      @(negedge clk);
      vectors++;
      if (rd1 !== 32'd0 || busy1 !== 1'b0) begin
         errors++;
         $display("FAIL post_sweep_r5: rd1=%h b1=%b, required 0/0", rd1, busy1);
      end
      step();
   endtask

   task automatic test_param();
      int          n;
      logic [63:0] val;
      n = 0;
      @(posedge clk);
      #1;
      rst2 = 1'b1;
      forever begin
         @(negedge clk);
         if (b_ready) break;
         n++;
         if (n >= 50) break;
      end
      vectors++;
      if (n != 8) begin
         errors++;
         $display("FAIL small_clear_length: got %0d cycles, required 8", n);
      end
      val = {$urandom, $urandom};
      b_we3 = 1'b1; b_a3 = 3'd7; b_wd3 = val;
      @(posedge clk);
      #1;
      b_we3 = 1'b0; b_a1 = 3'd7; b_a2 = 3'd0;
      @(negedge clk);
      vectors++;
      if (b_rd1 !== val || b_rd2 !== 64'd0 || b_busy1 !== 1'b0) begin
         errors++;
         $display("FAIL small_r7_roundtrip: rd1=%h rd2=%h b1=%b, required %h/0/0",
                  b_rd1, b_rd2, b_busy1, val);
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_write_read();
      test_scoreboard();
      test_bypass();
      test_random();
      test_reset_mid_clear();
      test_reset_mid_run();
      test_param();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports A1, A2  input  ADDR_W  read addresses, ports 1 and 2.
REQ-006 SHALL have ports RD1, RD2  output  DATA_W  combinational read data, ports 1 and 2.
REQ-007 SHALL have ports A3  input  ADDR_W, WD3  input  DATA_W, WE3  input  1  write address, data, enable.
REQ-008 SHALL have ports ISS  input  1, ISS_A  input  ADDR_W  issue strobe marking ISS_A as pending-write.
REQ-009 SHALL have ports BUSY1, BUSY2  output  1  pending-write flag of A1, A2.
REQ-010 SHALL have port READY  output  1  high once post-reset clear sequence completes.

Function
REQ-011 SHALL implement two states: CLEAR and RUN.
REQ-012 In CLEAR, a counter SHALL step 0..DEPTH-1, one cycle per entry, zeroing that entry and its pending bit.
REQ-013 CLEAR SHALL go to RUN on the cycle after the counter reaches DEPTH-1; the total is DEPTH cycles from reset release (32 by default).
REQ-014 READY SHALL be 0 in CLEAR and 1 in RUN.
REQ-015 In CLEAR: RD1/RD2 = 0, BUSY1/BUSY2 = 0; WE3 and ISS ignored.
REQ-016 In RUN: on clk edge with WE3=1 and A3!=0, Registers[A3] <= WD3 and pending[A3] <= 0.
REQ-017 In RUN: on clk edge with ISS=1 and ISS_A!=0, pending[ISS_A] <= 1.
REQ-018 Same edge, WE3 and ISS both to the same nonzero address: data written, pending ends 1 (issue wins).
REQ-019 Address 0: reads always 0, never pending, writes and issues to 0 discarded.
REQ-020 RD1 = Registers[A1], RD2 = Registers[A2] combinationally; BUSY1 = pending[A1], BUSY2 = pending[A2].
REQ-021 A1==A2 SHALL return identical data and flags on both ports.

Reset
REQ-022 rst low SHALL asynchronously force state=CLEAR, counter=0, READY=0, RD1=RD2=0, BUSY1=BUSY2=0.
REQ-023 Register contents SHALL NOT be reset in one step; they become zero only through the CLEAR sweep.
REQ-024 Reset asserted mid-CLEAR or mid-RUN SHALL restart the sweep from entry 0.

Configuration
REQ-025 Macro RF_BYPASS_EN defined: in RUN, if WE3=1 and A3==A1!=0, RD1=WD3 and BUSY1=0 in the same cycle; same for port 2.
REQ-026 Macro RF_BYPASS_EN undefined: reads return the pre-edge register value and pending flag; a write is visible the cycle after its edge.

Verification
REQ-027 Release rst, poll READY -> READY=0 for exactly 32 cycles, then 1; all 32 reads return 0.
REQ-028 RUN: write 0xDEADBEEF to r5, next cycle A1=5 -> RD1=0xDEADBEEF; write 0x1234 to r0, A2=0 -> RD2=0.
REQ-029 ISS with ISS_A=7 -> BUSY1=1 for A1=7; later WE3 A3=7 WD3=0x55 -> BUSY1=0, RD1=0x55; same-edge ISS and WE3 to r9 -> BUSY=1, data written.
REQ-030 WE3 A3=3 WD3=0xA5A5A5A5 with A1=3, same cycle -> RD1=0xA5A5A5A5, BUSY1=0 with RF_BYPASS_EN; old value without it.
REQ-031 Pull rst low 10 cycles into CLEAR, and again in RUN with r5 written -> READY drops immediately, sweep restarts, 32 cycles later r5 reads 0.
REQ-032 Parameter run DATA_W=64, ADDR_W=3 -> CLEAR lasts 8 cycles, 64-bit write/read to r7 round-trips.
